datapath_legv8_pipe: RTL and testbench
======================================

# datapath_legv8_pipe

Parametrised, two-stage successor to the single-cycle LEGv8 datapath. It accepts one control word per handshake, then reads operands with write-back bypass, executes on a parametric ALU, and performs data-memory access over an external req/ack port that tolerates wait states. It writes results back to a 2^REG_AW-entry register file, with the top register hard-wired to zero (XZR). It sits between the control unit and the data memory, and replaces the shared tri-state data bus with an internal write-back mux.

## Interface
- DATA_W, 64, datapath width; must be a power of two, 8 or more.
- REG_AW, 5, register address width; the register file has 2^REG_AW entries.
- MEM_AW, 8, word-address width of the data memory.
- CW_W, 3*REG_AW+10, derived control word width, not overridable.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- cw  in  CW_W  control word, MSB first: {sa, sb, da, reg_write, mem_write, fs[4:0], b_sel, sl, wb_sel}.
- cw_valid  in  1  cw and constant are valid.
- cw_ready  out  1  datapath accepts cw this cycle.
- constant  in  DATA_W  immediate operand, used when b_sel=1.
- mem_req  out  1  memory access pending.
- mem_we  out  1  write access (mem_write).
- mem_addr  out  MEM_AW  ALU result [MEM_AW-1:0].
- mem_wdata  out  DATA_W  register-B value; never the constant.
- mem_rdata  in  DATA_W  read data, valid while mem_ack is high.
- mem_ack  in  1  completes the current access.
- status  out  5  {V,C,N,Z} registered in [4:1]; [0] is the live Z of the EX result.
- wb_valid  out  1  a write-back occurs at this edge.
- wb_addr  out  REG_AW  write-back address.
- wb_data  out  DATA_W  write-back value.

## Operation
- Accept: a control word is taken when cw_valid && cw_ready. At that edge the block:
  - reads A=R[sa] and Breg=R[sb];
  - forms B = b_sel ? constant : Breg;
  - latches A, B, Breg and the control fields into the EX register; ex_valid is set.
- XZR: reading register 2^REG_AW-1 returns 0, and writes to it are discarded.
- Bypass: when the EX stage completes in the same edge with reg_write=1 and da equal to sa (or sb), and da is not XZR, the capture uses wb_data instead of the register file.
- ALU: fs[4:2] selects the operation. 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR; 110 and 111 produce 0.
  - fs[1] inverts A.
  - fs[0] inverts B and sets carry-in to 1, so SUB = 01001.
  - Shift amount is B[log2(DATA_W)-1:0].
- Flags:
  - N = result MSB; Z = result is zero.
  - C = adder carry-out; V = signed overflow. Both are defined for ADD only and are 0 for every other operation.
- Memory op: mem_op = mem_write || wb_sel. mem_req = ex_valid && mem_op.
  - mem_we, mem_addr and mem_wdata stay stable while mem_req is high.
- Completion: ex_done = ex_valid && (!mem_op || mem_ack).
  - On ex_done with reg_write=1, R[da] is loaded with wb_sel ? mem_rdata : alu_result.
  - wb_valid = ex_done && reg_write && da!=XZR.
- Status register: loads {V,C,N,Z} on ex_done && sl; otherwise it holds.
- status[0]: equals the live Z while ex_valid is high, and 0 otherwise.
- cw_ready = !ex_valid || ex_done, so the next word can be accepted in the completing cycle.
- Illegal control words: mem_write=1 with wb_sel=1 performs a write, then loads mem_rdata captured at ack. Benches must not generate this combination.

## Timing
- Reset values (asynchronous, immediate):
  - ex_valid=0; all registers=0; status register=0.
  - mem_req=0; wb_valid=0; cw_ready=1 once reset deasserts.
- Non-memory word accepted at edge E0: EX occupies cycle 1, write-back and flag load happen at E1. Throughput is one word per cycle.
- Memory word accepted at E0: mem_req rises in cycle 1 and completes at the first edge with mem_ack high, after ≥1 cycle. cw_ready is low in every wait cycle.
- mem_ack sampled while mem_req is low is ignored.
- Reset asserted mid-access:
  - the in-flight word is dropped with no write-back;
  - mem_req falls asynchronously;
  - the register file is cleared.
- Back-to-back dependent words need no bubbles; the bypass covers distance 1.
- Distance ≥2 reads the register file, which is already written.

## Structure
- Package datapath_legv8_pkg holds:
  - the fs encodings (FS_AND … FS_LSR, FS_SUB);
  - the control-word field offsets as functions of REG_AW;
  - the status bit indices.
- Sub-module regfile_nxm(DATA_W, REG_AW): 2 asynchronous read ports, 1 synchronous write port, async active-low clear, XZR handling inside.
- The ALU, bypass and handshake logic stay in the top module.

## Test plan
- Reset, then ADD of R1=5 and constant 7 with sl=1 → wb_data=12 to R2 one edge after accept; status[4:1]=0000.
- SUB (fs=01001) of R1=5 minus R1 with sl=1 → result 0, Z=1, C=1, V=0; R3 written 0; status[1]=1.
- Dependent pair: R4←R1+const 1, then immediately R5←R4+R4, no idle cycle → R5=12 (bypass). cw_ready stays 1.
- Store Breg=0xDEAD to address 0x10 with mem_ack delayed 3 cycles → mem_req high for 3 cycles, cw_ready low, mem_we=1, mem_wdata=0xDEAD. Then load from 0x10 with mem_rdata=0xDEAD → R6=0xDEAD at the ack edge.
- Write 0x55 to XZR, then read XZR → wb_valid=0 and the operand reads 0. ADD 0x7FFF…F+1 → V=1, N=1.
- Assert reset during a pending load → mem_req drops the same cycle, no write-back, all registers read 0 after release.

Source files
------------

// File: rtl/datapath_legv8_pkg.sv
// Shared encodings for the pipelined LEGv8 datapath: ALU function codes,
// control-word field offsets and status bit positions.
package datapath_legv8_pkg;

    // fs encodings: fs[4:2] operation, fs[1] invert A, fs[0] invert B + carry-in
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;

    // Low control-word fields sit at fixed offsets
    localparam int unsigned CW_WB_SEL    = 0;
    localparam int unsigned CW_SL        = 1;
    localparam int unsigned CW_B_SEL     = 2;
    localparam int unsigned CW_FS_LO     = 3;
    localparam int unsigned CW_MEM_WRITE = 8;
    localparam int unsigned CW_REG_WRITE = 9;

    // Register-address fields scale with the register address width
    function automatic int unsigned cw_width(input int unsigned reg_aw);
        return 3 * reg_aw + 10;
    endfunction

    function automatic int unsigned cw_da_lo(input int unsigned reg_aw);
        return 10 + 0 * reg_aw;
    endfunction

    function automatic int unsigned cw_sb_lo(input int unsigned reg_aw);
        return 10 + reg_aw;
    endfunction

    function automatic int unsigned cw_sa_lo(input int unsigned reg_aw);
        return 10 + 2 * reg_aw;
    endfunction

    // status port bit positions
    localparam int unsigned ST_ZLIVE = 0;
    localparam int unsigned ST_Z     = 1;
    localparam int unsigned ST_N     = 2;
    localparam int unsigned ST_C     = 3;
    localparam int unsigned ST_V     = 4;

endpackage

// File: rtl/datapath_legv8_pipe_regfile.sv
// Register file: two async read ports, one sync write port, top entry reads 0.
module regfile_nxm #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    localparam int unsigned N_REGS = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] XZR = '1;

    logic [DATA_W-1:0] regs [N_REGS];

    // Storage with async clear; writes to XZR are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_REGS); i++) regs[i] <= '0;
        end else if (we && (wa != XZR)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == XZR) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == XZR) ? '0 : regs[rb_addr];

endmodule

// File: rtl/datapath_legv8_pipe.sv
// Two-stage LEGv8 datapath: operand read with write-back bypass, then
// ALU execute / memory access / write-back in the EX stage.
module datapath_legv8_pipe
    import datapath_legv8_pkg::*;
#(
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned REG_AW = 5,
    parameter  int unsigned MEM_AW = 8,
    localparam int unsigned CW_W   = cw_width(REG_AW)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CW_W-1:0]   cw,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [DATA_W-1:0] constant,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [4:0]        status,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned SA_LO = cw_sa_lo(REG_AW);
    localparam int unsigned SB_LO = cw_sb_lo(REG_AW);
    localparam int unsigned DA_LO = cw_da_lo(REG_AW);
    localparam logic [REG_AW-1:0] XZR = '1;

    // Control-word decode
    logic [REG_AW-1:0] cw_sa, cw_sb, cw_da;
    assign cw_sa = cw[SA_LO +: REG_AW];
    assign cw_sb = cw[SB_LO +: REG_AW];
    assign cw_da = cw[DA_LO +: REG_AW];

    // EX stage state
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a, ex_b, ex_breg;
    logic [REG_AW-1:0] ex_da;
    logic              ex_rw, ex_mw, ex_sl, ex_wbsel;
    logic [4:0]        ex_fs;
    logic [3:0]        flags_q;

    logic [DATA_W-1:0] rf_a, rf_b, a_cap, breg_cap, b_cap;
    logic              mem_op, ex_done, accept;

    regfile_nxm #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk     (clock),
        .rst_n   (reset),
        .ra_addr (cw_sa),
        .rb_addr (cw_sb),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      (wb_valid),
        .wa      (ex_da),
        .wd      (wb_data)
    );

    // Operand capture with distance-1 bypass from the completing write-back
    always_comb begin
        a_cap    = (wb_valid && (ex_da == cw_sa)) ? wb_data : rf_a;
        breg_cap = (wb_valid && (ex_da == cw_sb)) ? wb_data : rf_b;
        b_cap    = cw[CW_B_SEL] ? constant : breg_cap;
    end

    // ALU with flag generation; C and V only meaningful for ADD
    logic [DATA_W-1:0] a_op, b_op, alu_res;
    logic [DATA_W:0]   sum_ext;
    logic [SH_W-1:0]   shamt;
    logic              alu_c, alu_v, alu_z;
    always_comb begin
        a_op    = ex_fs[1] ? ~ex_a : ex_a;
        b_op    = ex_fs[0] ? ~ex_b : ex_b;
        sum_ext = {1'b0, a_op} + {1'b0, b_op} + (DATA_W+1)'(ex_fs[0]);
        shamt   = b_op[SH_W-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ex_fs[4:2])
            OP_AND: alu_res = a_op & b_op;
            OP_OR:  alu_res = a_op | b_op;
            OP_ADD: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (a_op[DATA_W-1] == b_op[DATA_W-1]) &&
                          (sum_ext[DATA_W-1] != a_op[DATA_W-1]);
            end
            OP_XOR: alu_res = a_op ^ b_op;
            OP_LSL: alu_res = a_op << shamt;
            OP_LSR: alu_res = a_op >> shamt;
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == '0);
    end

    // Handshake, memory port and write-back
    assign mem_op    = ex_mw | ex_wbsel;
    assign mem_req   = ex_valid & mem_op;
    assign ex_done   = ex_valid & (~mem_op | mem_ack);
    assign cw_ready  = ~ex_valid | ex_done;
    assign accept    = cw_valid & cw_ready;
    assign mem_we    = ex_mw;
    assign mem_addr  = alu_res[MEM_AW-1:0];
    assign mem_wdata = ex_breg;
    assign wb_valid  = ex_done & ex_rw & (ex_da != XZR);
    assign wb_addr   = ex_da;
    assign wb_data   = ex_wbsel ? mem_rdata : alu_res;
    assign status    = {flags_q, ex_valid & alu_z};

    // EX register: load on accept, retire on completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_breg  <= '0;
            ex_da    <= '0;
            ex_rw    <= 1'b0;
            ex_mw    <= 1'b0;
            ex_sl    <= 1'b0;
            ex_wbsel <= 1'b0;
            ex_fs    <= '0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_a     <= a_cap;
            ex_b     <= b_cap;
            ex_breg  <= breg_cap;
            ex_da    <= cw_da;
            ex_rw    <= cw[CW_REG_WRITE];
            ex_mw    <= cw[CW_MEM_WRITE];
            ex_sl    <= cw[CW_SL];
            ex_wbsel <= cw[CW_WB_SEL];
            ex_fs    <= cw[CW_FS_LO +: 5];
        end else if (ex_done) begin
            ex_valid <= 1'b0;
        end
    end

    // Status flags {V,C,N,Z} load when a flag-setting word completes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (ex_done && ex_sl) begin
            flags_q <= {alu_v, alu_c, alu_res[DATA_W-1], alu_z};
        end
    end

endmodule

// File: tb/tb_datapath_legv8_pipe.sv
// Directed bench for datapath_legv8_pipe with a write-back scoreboard.
module tb_datapath_legv8_pipe;
    import datapath_legv8_pkg::*;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 5;
    localparam int unsigned MAW = 8;
    localparam int unsigned CWW = 3 * AW + 10;

    logic           clock, reset;
    logic [CWW-1:0] cw;
    logic           cw_valid, cw_ready;
    logic [DW-1:0]  constant;
    logic           mem_req, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata, mem_rdata;
    logic           mem_ack;
    logic [4:0]     status;
    logic           wb_valid;
    logic [AW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;
    wb_t sb_q[$];

    datapath_legv8_pipe #(.DATA_W(DW), .REG_AW(AW), .MEM_AW(MAW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cw        (cw),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .constant  (constant),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .status    (status),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [CWW-1:0] mk(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                                          input logic [AW-1:0] da, input logic rw, input logic mw,
                                          input logic [4:0] fs, input logic bsel, input logic sl,
                                          input logic wbsel);
        return {sa, sb, da, rw, mw, fs, bsel, sl, wbsel};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Pop and compare whenever the DUT announces a write-back
    task automatic sample_wb(input string tag);
        wb_t e;
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk({tag, " spurious wb_valid"}, 64'(wb_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk({tag, " wb_addr"}, 64'(wb_addr), 64'(e.addr));
                chk({tag, " wb_data"}, 64'(wb_data), 64'(e.data));
            end
        end
    endtask

    // Present one word at a falling edge; returns at the next falling edge (EX cycle)
    task automatic send(input string tag, input logic [CWW-1:0] w, input logic [DW-1:0] k);
        chk({tag, " cw_ready"}, 64'(cw_ready), 64'd1);
        cw       = w;
        constant = k;
        cw_valid = 1'b1;
        @(negedge clock);
        sample_wb(tag);
        cw_valid = 1'b0;
    endtask

    localparam logic [AW-1:0] XZR = 5'd31;

    initial begin
        reset     = 1'b0;
        cw        = '0;
        cw_valid  = 1'b0;
        constant  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst wb_valid", 64'(wb_valid), 64'd0);
        chk("rst status", 64'(status), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle cw_ready", 64'(cw_ready), 64'd1);

        // R1 = 5, then R2 = R1 + 7 with flags
        expect_wb(5'd1, 64'd5);
        send("ld r1", mk(XZR, XZR, 5'd1, 1, 0, FS_ADD, 1, 0, 0), 64'd5);
        expect_wb(5'd2, 64'd12);
        send("add", mk(5'd1, XZR, 5'd2, 1, 0, FS_ADD, 1, 1, 0), 64'd7);
        chk("add zlive", 64'(status[ST_ZLIVE]), 64'd0);
        @(negedge clock);
        chk("add flags", 64'(status[4:1]), 64'h0);

        // R3 = R1 - R1: Z=1, C=1, V=0, N=0
        expect_wb(5'd3, 64'd0);
        send("sub", mk(5'd1, 5'd1, 5'd3, 1, 0, FS_SUB, 0, 1, 0), 64'd0);
        chk("sub zlive", 64'(status[ST_ZLIVE]), 64'd1);
        @(negedge clock);
        chk("sub flags", 64'(status[4:1]), 64'h5);
        chk("idle zlive", 64'(status[ST_ZLIVE]), 64'd0);

        // Dependent pair through the bypass, no bubble
        expect_wb(5'd4, 64'd6);
        send("dep1", mk(5'd1, XZR, 5'd4, 1, 0, FS_ADD, 1, 0, 0), 64'd1);
        expect_wb(5'd5, 64'd12);
        send("dep2", mk(5'd4, 5'd4, 5'd5, 1, 0, FS_ADD, 0, 0, 0), 64'd0);

        // R7 = 0xDEAD, then store R7 to 0x10 with a 3-cycle access
        expect_wb(5'd7, 64'hDEAD);
        send("ld r7", mk(XZR, XZR, 5'd7, 1, 0, FS_ADD, 1, 0, 0), 64'hDEAD);
        send("st", mk(XZR, 5'd7, 5'd0, 0, 1, FS_ADD, 1, 0, 0), 64'h10);
        chk("st req c1", 64'(mem_req), 64'd1);
        chk("st we", 64'(mem_we), 64'd1);
        chk("st addr", 64'(mem_addr), 64'h10);
        chk("st wdata", 64'(mem_wdata), 64'hDEAD);
        chk("st ready c1", 64'(cw_ready), 64'd0);
        @(negedge clock);
        chk("st req c2", 64'(mem_req), 64'd1);
        chk("st ready c2", 64'(cw_ready), 64'd0);
        chk("st addr c2", 64'(mem_addr), 64'h10);
        @(negedge clock);
        chk("st req c3", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        #1;
        chk("st ready ack", 64'(cw_ready), 64'd1);
        chk("st no wb", 64'(wb_valid), 64'd0);
        @(negedge clock);
        mem_ack = 1'b0;
        chk("st req done", 64'(mem_req), 64'd0);

        // Load R6 from 0x10, acked in the first wait cycle
        expect_wb(5'd6, 64'hDEAD);
        send("ldm", mk(XZR, XZR, 5'd6, 1, 0, FS_ADD, 1, 0, 1), 64'h10);
        chk("ldm req", 64'(mem_req), 64'd1);
        chk("ldm we", 64'(mem_we), 64'd0);
        chk("ldm addr", 64'(mem_addr), 64'h10);
        mem_rdata = 64'hDEAD;
        mem_ack   = 1'b1;
        #1;
        sample_wb("ldm ack");
        @(negedge clock);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        expect_wb(5'd8, 64'hDEAD);
        send("rd r6", mk(5'd6, XZR, 5'd8, 1, 0, FS_ADD, 0, 0, 0), 64'd0);

        // XZR write is discarded, and an immediate read of XZR returns 0
        send("wr xzr", mk(XZR, XZR, XZR, 1, 0, FS_ADD, 1, 0, 0), 64'h55);
        chk("xzr wb_valid", 64'(wb_valid), 64'd0);
        expect_wb(5'd9, 64'd0);
        send("rd xzr", mk(XZR, XZR, 5'd9, 1, 0, FS_ADD, 0, 0, 0), 64'd0);

        // Signed overflow: 0x7FFF...F + 1
        expect_wb(5'd10, 64'h7FFF_FFFF_FFFF_FFFF);
        send("ld max", mk(XZR, XZR, 5'd10, 1, 0, FS_ADD, 1, 0, 0), 64'h7FFF_FFFF_FFFF_FFFF);
        expect_wb(5'd11, 64'h8000_0000_0000_0000);
        send("ovf", mk(5'd10, XZR, 5'd11, 1, 0, FS_ADD, 1, 1, 0), 64'd1);
        @(negedge clock);
        chk("ovf flags", 64'(status[4:1]), 64'hA);

        // Reset during a pending load
        send("ld pend", mk(XZR, XZR, 5'd12, 1, 0, FS_ADD, 1, 0, 1), 64'h20);
        chk("pend req", 64'(mem_req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst mem_req", 64'(mem_req), 64'd0);
        chk("arst wb_valid", 64'(wb_valid), 64'd0);
        chk("arst status", 64'(status), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        expect_wb(5'd13, 64'd0);
        send("rd clr a", mk(5'd1, 5'd2, 5'd13, 1, 0, FS_ADD, 0, 0, 0), 64'd0);
        expect_wb(5'd14, 64'd0);
        send("rd clr b", mk(5'd11, 5'd7, 5'd14, 1, 0, FS_OR, 0, 0, 0), 64'd0);
        @(negedge clock);
        chk("sb empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
